// File: rtl/ps2_scan_code_set2.sv
// Set-2 scan code constants, modifier codes, ignored bytes and decoder states.
package ps2_scan_code_set2;

  // Prefix bytes
  localparam logic [7:0] PREFIX_E0 = 8'hE0;
  localparam logic [7:0] PREFIX_F0 = 8'hF0;
  localparam logic [7:0] PREFIX_E1 = 8'hE1;

  // Non-extended modifier codes
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_LCTRL  = 8'h14;
  localparam logic [7:0] SC_LALT   = 8'h11;

  // E0-prefixed modifier codes
  localparam logic [7:0] SC_RCTRL_E = 8'h14;
  localparam logic [7:0] SC_ALTGR_E = 8'h11;
  localparam logic [7:0] SC_LGUI_E  = 8'h1F;
  localparam logic [7:0] SC_RGUI_E  = 8'h27;

  // E0-prefixed fake shifts wrapped around Print Screen / Insert etc.
  localparam logic [7:0] SC_FAKE_SHIFT_L = 8'h12;
  localparam logic [7:0] SC_FAKE_SHIFT_R = 8'h59;

  // Bytes following E1 that make up the rest of the Pause sequence
  localparam int E1_SKIP_BYTES = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0,
    ST_E1_SKIP
  } kbd_state_e;

  typedef struct packed {
    logic lshift;
    logic rshift;
    logic lctrl;
    logic rctrl;
    logic lalt;
    logic altgr;
    logic lgui;
    logic rgui;
  } mod_flags_t;

  // Keyboard responses / error bytes that never start a key sequence
  function automatic logic is_ignored(input logic [7:0] b);
    logic r;
    r = 1'b0;
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_prefix_timeout.sv
// Clearable idle counter; pulses done on the cycle the count reaches LIMIT
// and wraps back to zero at the same edge.
module ps2_prefix_timeout #(
  parameter int LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins, otherwise count idle cycles up to LIMIT
  always_comb begin
    count_d = count_q;
    done    = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      if (count_q == LAST) begin
        done    = 1'b1;
        count_d = '0;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/ps2_keyboard_state.sv
// Decodes set-2 prefixes, tracks modifier keys and emits one make event per
// non-modifier key press, tagged with the current modifier state.
module ps2_keyboard_state
  import ps2_scan_code_set2::*;
#(
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] PAUSE_CODE     = 8'h77
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_code_ready,
  input  logic [7:0] scan_code,
  output logic       keyboard_state_ready,
  output logic [7:0] scan_code_out,
  output logic       scan_code_extended,
  output logic       keyboard_shift,
  output logic       keyboard_ctrl,
  output logic       keyboard_alt,
  output logic       keyboard_altgr,
  output logic       keyboard_meta
);

  kbd_state_e state_q, state_d;
  logic [2:0] skip_q, skip_d;
  mod_flags_t flags_q, flags_d;
  logic       ready_q, ready_d;
  logic [7:0] code_q, code_d;
  logic       ext_q, ext_d;

  logic key_valid;
  logic key_ext;
  logic key_break;
  logic timeout_done;
  logic timeout_clear;
  logic timeout_enable;

  // Prefix timer only runs while a partial sequence is pending
  assign timeout_enable = (state_q != ST_IDLE) && !scan_code_ready;
  assign timeout_clear  = scan_code_ready || (state_q == ST_IDLE);

  ps2_prefix_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (timeout_clear),
    .enable (timeout_enable),
    .done   (timeout_done)
  );

  // Prefix FSM, modifier tracking and event generation
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    flags_d   = flags_q;
    ready_d   = 1'b0;
    code_d    = code_q;
    ext_d     = ext_q;
    key_valid = 1'b0;
    key_ext   = 1'b0;
    key_break = 1'b0;

    if (scan_code_ready) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == PREFIX_E0) begin
            state_d = ST_E0;
          end else if (scan_code == PREFIX_F0) begin
            state_d = ST_F0;
          end else if (scan_code == PREFIX_E1) begin
            state_d = ST_E1_SKIP;
            skip_d  = 3'(E1_SKIP_BYTES);
          end else if (!is_ignored(scan_code)) begin
            key_valid = 1'b1;
          end
        end
        ST_E0: begin
          if (scan_code == PREFIX_F0) begin
            state_d = ST_E0F0;
          end else begin
            key_valid = 1'b1;
            key_ext   = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        ST_F0: begin
          key_valid = 1'b1;
          key_break = 1'b1;
          state_d   = ST_IDLE;
        end
        ST_E0F0: begin
          key_valid = 1'b1;
          key_ext   = 1'b1;
          key_break = 1'b1;
          state_d   = ST_IDLE;
        end
        ST_E1_SKIP: begin
          // Pause has no break code; the whole 8-byte burst is one press
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
            code_d  = PAUSE_CODE;
            ext_d   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout_done) begin
      state_d = ST_IDLE;
    end

    if (key_valid) begin
      if (!key_ext) begin
        case (scan_code)
          SC_LSHIFT: flags_d.lshift = !key_break;
          SC_RSHIFT: flags_d.rshift = !key_break;
          SC_LCTRL:  flags_d.lctrl  = !key_break;
          SC_LALT:   flags_d.lalt   = !key_break;
          default: begin
            if (!key_break) begin
              ready_d = 1'b1;
              code_d  = scan_code;
              ext_d   = 1'b0;
            end
          end
        endcase
      end else begin
        case (scan_code)
          SC_RCTRL_E: flags_d.rctrl = !key_break;
          SC_ALTGR_E: flags_d.altgr = !key_break;
          SC_LGUI_E:  flags_d.lgui  = !key_break;
          SC_RGUI_E:  flags_d.rgui  = !key_break;
          SC_FAKE_SHIFT_L, SC_FAKE_SHIFT_R: begin
            // Fake shifts are discarded so they never disturb real Shift
          end
          default: begin
            if (!key_break) begin
              ready_d = 1'b1;
              code_d  = scan_code;
              ext_d   = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      flags_q <= '0;
      ready_q <= 1'b0;
      code_q  <= '0;
      ext_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      flags_q <= flags_d;
      ready_q <= ready_d;
      code_q  <= code_d;
      ext_q   <= ext_d;
    end
  end

  assign keyboard_state_ready = ready_q;
  assign scan_code_out        = code_q;
  assign scan_code_extended   = ext_q;
  assign keyboard_shift       = flags_q.lshift | flags_q.rshift;
  assign keyboard_ctrl        = flags_q.lctrl | flags_q.rctrl;
  assign keyboard_alt         = flags_q.lalt;
  assign keyboard_altgr       = flags_q.altgr;
  assign keyboard_meta        = flags_q.lgui | flags_q.rgui;

endmodule

// File: tb/tb_ps2_keyboard_state.sv
// Directed and randomized key-action stimulus checked against a key-level model.
module tb_ps2_keyboard_state;

  localparam int T = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_code_ready;
  logic [7:0] scan_code;
  logic       keyboard_state_ready;
  logic [7:0] scan_code_out;
  logic       scan_code_extended;
  logic       keyboard_shift;
  logic       keyboard_ctrl;
  logic       keyboard_alt;
  logic       keyboard_altgr;
  logic       keyboard_meta;

  ps2_keyboard_state #(
    .TIMEOUT_CYCLES (T),
    .PAUSE_CODE     (8'h77)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .scan_code_ready      (scan_code_ready),
    .scan_code            (scan_code),
    .keyboard_state_ready (keyboard_state_ready),
    .scan_code_out        (scan_code_out),
    .scan_code_extended   (scan_code_extended),
    .keyboard_shift       (keyboard_shift),
    .keyboard_ctrl        (keyboard_ctrl),
    .keyboard_alt         (keyboard_alt),
    .keyboard_altgr       (keyboard_altgr),
    .keyboard_meta        (keyboard_meta)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: which physical modifier keys are held, and the last reported key.
  // Index: 0 lshift, 1 rshift, 2 lctrl, 3 rctrl, 4 lalt, 5 altgr, 6 lgui, 7 rgui
  logic [7:0] held      = '0;
  logic [7:0] last_code = '0;
  logic       last_ext  = 1'b0;

  logic [7:0] mod_code [8] = '{8'h12, 8'h59, 8'h14, 8'h14, 8'h11, 8'h11, 8'h1F, 8'h27};
  logic       mod_ext  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0] norm_codes [16] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                  8'h45, 8'h16, 8'h66, 8'h5A, 8'h29, 8'h0D, 8'h76, 8'h05};
  logic [7:0] ext_codes [8] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h70, 8'h71, 8'h69, 8'h7A};

  function automatic logic [7:0] exp_mods();
    return {3'b000, held[0] | held[1], held[2] | held[3], held[4], held[5], held[6] | held[7]};
  endfunction

  function automatic logic [7:0] obs_mods();
    return {3'b000, keyboard_shift, keyboard_ctrl, keyboard_alt, keyboard_altgr, keyboard_meta};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit exp_ready);
    chk({tag, ".ready"}, {7'd0, keyboard_state_ready}, {7'd0, exp_ready});
    chk({tag, ".mods"}, obs_mods(), exp_mods());
    chk({tag, ".code"}, scan_code_out, last_code);
    chk({tag, ".ext"}, {7'd0, scan_code_extended}, {7'd0, last_ext});
  endtask

  // One byte strobe; ev says whether this byte completes a reportable key press
  task automatic send(input logic [7:0] b, input bit ev, input logic [7:0] c, input bit x);
    if (ev) begin
      last_code = c;
      last_ext  = x;
    end
    scan_code       = b;
    scan_code_ready = 1'b1;
    @(posedge clk);
    #1;
    scan_code_ready = 1'b0;
    check_all($sformatf("byte_%h", b), ev);
    $display("byte %h ready=%b code=%h ext=%b mods=%05b", b, keyboard_state_ready,
             scan_code_out, scan_code_extended, obs_mods() & 8'h1F);
  endtask

  task automatic send_nb(input logic [7:0] b);
    send(b, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("idle.ready", {7'd0, keyboard_state_ready}, 8'h00);
    end
  endtask

  task automatic key_press(input logic [7:0] c, input bit x);
    if (x) send_nb(8'hE0);
    send(c, 1'b1, c, x);
  endtask

  task automatic key_release(input logic [7:0] c, input bit x);
    if (x) send_nb(8'hE0);
    send_nb(8'hF0);
    send_nb(c);
  endtask

  task automatic mod_act(input int i, input bit brk);
    if (mod_ext[i]) send_nb(8'hE0);
    if (brk) send_nb(8'hF0);
    held[i] = !brk;
    send_nb(mod_code[i]);
  endtask

  task automatic pause_key();
    logic [7:0] seq [7];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0};
    for (int i = 0; i < 7; i++) send_nb(seq[i]);
    send(8'h77, 1'b1, 8'h77, 1'b1);
  endtask

  task automatic prtsc(input bit brk);
    if (!brk) begin
      send_nb(8'hE0); send_nb(8'h12);
      send_nb(8'hE0); send(8'h7C, 1'b1, 8'h7C, 1'b1);
    end else begin
      send_nb(8'hE0); send_nb(8'hF0); send_nb(8'h7C);
      send_nb(8'hE0); send_nb(8'hF0); send_nb(8'h12);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    held      = '0;
    last_code = '0;
    last_ext  = 1'b0;
    check_all("reset", 1'b0);
  endtask

  initial begin
    reset           = 1'b1;
    scan_code_ready = 1'b0;
    scan_code       = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("por", 1'b0);

    // Plain make
    key_press(8'h1C, 1'b0);
    idle(2);

    // Shift held around a key
    mod_act(0, 1'b0);
    key_press(8'h1C, 1'b0);
    key_release(8'h1C, 1'b0);
    mod_act(0, 1'b1);
    idle(1);

    // AltGr does not make the following key extended
    mod_act(5, 1'b0);
    key_press(8'h45, 1'b0);
    mod_act(5, 1'b1);

    // Print Screen with fake shifts
    prtsc(1'b0);
    prtsc(1'b1);

    // Pause sequence
    pause_key();
    idle(1);

    // Typematic repeat, back to back
    key_press(8'h1C, 1'b0);
    key_press(8'h1C, 1'b0);
    key_press(8'h1C, 1'b0);

    // Ignored response bytes in IDLE
    send_nb(8'hFA);
    send_nb(8'hAA);
    send_nb(8'h00);

    // Prefix abandoned after exactly T idle cycles
    send_nb(8'hE0);
    idle(T);
    key_press(8'h75, 1'b0);
    // One cycle short of the timeout keeps the prefix
    send_nb(8'hE0);
    idle(T - 1);
    send(8'h75, 1'b1, 8'h75, 1'b1);
    // Abandoned break prefix: following byte is a make
    send_nb(8'hF0);
    idle(T);
    key_press(8'h1C, 1'b0);

    // Reset mid-sequence
    mod_act(0, 1'b0);
    send_nb(8'hF0);
    do_reset();
    key_press(8'h1C, 1'b0);

    // Randomized key actions
    for (int n = 0; n < 200; n++) begin
      int k;
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2: key_press(norm_codes[$urandom_range(0, 15)], 1'b0);
        3:       key_release(norm_codes[$urandom_range(0, 15)], 1'b0);
        4, 5:    key_press(ext_codes[$urandom_range(0, 7)], 1'b1);
        6:       key_release(ext_codes[$urandom_range(0, 7)], 1'b1);
        7:       begin
                   int m;
                   m = $urandom_range(0, 7);
                   mod_act(m, held[m]);
                 end
        8:       pause_key();
        default: prtsc(1'($urandom_range(0, 1)));
      endcase
      idle($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
